cyc_counter_prog: RTL and testbench

Programmable prescaled modulo counter: a prescaler divides `clk` by a runtime-set period, and each prescaler expiry steps a bounded up/down counter. Period and limit are configurable at runtime. The block provides load, tick/wrap strobes and an optional one-shot mode. It replaces fixed-divide, fixed-modulus cycle counters in round/phase sequencing logic and drives timers, display multiplexing and sequence step indices.

---
 rtl/cyc_counter_prog.sv | 127 ++++++++++++
 tb/tb_cyc_counter_prog.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cyc_counter_prog.sv
// Prescaled up/down modulo counter with runtime period/limit, load and tick/wrap strobes; all outputs registered, one-edge config latency, no backpressure.
// One-shot stop-at-terminal mode is compiled in only when CYC_COUNTER_ONESHOT_EN is defined.
module cyc_counter_prog #(
  parameter int PRESCALE_W = 30,
  parameter int CNT_W      = 3,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  cfg_wr,
  input  logic [PRESCALE_W-1:0] period_in,
  input  logic [CNT_W-1:0]      limit_in,
  input  logic                  load,
  input  logic [CNT_W-1:0]      load_val,
  input  logic                  oneshot,
  output logic [CNT_W-1:0]      out,
  output logic                  tick,
  output logic                  wrap,
  output logic                  done
);

  localparam logic [PRESCALE_W-1:0] P_ONE        = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_DEF_PERIOD =
      (DEF_PERIOD == 0) ? P_ONE : PRESCALE_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0]      P_DEF_LIMIT  = CNT_W'(DEF_LIMIT);
  localparam logic [CNT_W-1:0]      P_CNT_ONE    = CNT_W'(1);

  logic [PRESCALE_W-1:0] r_period;
  logic [CNT_W-1:0]      r_limit;
  logic [PRESCALE_W-1:0] r_cyc;
  logic [CNT_W-1:0]      r_out;
  logic                  r_tick;
  logic                  r_wrap;
  logic                  r_done;

  logic [PRESCALE_W-1:0] w_period_nxt;
  logic [CNT_W-1:0]      w_limit_nxt;
  logic [PRESCALE_W-1:0] w_cyc_nxt;
  logic [CNT_W-1:0]      w_out_nxt;
  logic                  w_tick_nxt;
  logic                  w_wrap_nxt;
  logic                  w_done_nxt;
  logic                  w_oneshot;
  logic                  w_term;
  logic [PRESCALE_W-1:0] w_cfg_period;

`ifdef CYC_COUNTER_ONESHOT_EN
  assign w_oneshot = oneshot;
`else
  logic w_unused;
  assign w_oneshot = 1'b0;
  assign w_unused  = oneshot;
`endif

  // Terminal step: the step that would carry past the range end in the current direction.
  assign w_term       = up ? (r_out == r_limit) : (r_out == '0);
  assign w_cfg_period = (period_in == '0) ? P_ONE : period_in;

  always_comb begin
    w_period_nxt = r_period;
    w_limit_nxt  = r_limit;
    w_cyc_nxt    = r_cyc;
    w_out_nxt    = r_out;
    w_tick_nxt   = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_done_nxt   = r_done;

    if (cfg_wr) begin
      w_period_nxt = w_cfg_period;
      w_limit_nxt  = limit_in;
      w_cyc_nxt    = w_cfg_period;
      w_out_nxt    = up ? '0 : limit_in;
      w_done_nxt   = 1'b0;
    end else if (load) begin
      w_out_nxt  = (load_val > r_limit) ? r_limit : load_val;
      w_cyc_nxt  = r_period;
      w_done_nxt = 1'b0;
    end else if (en && !r_done) begin
      if (r_cyc != P_ONE) begin
        w_cyc_nxt = r_cyc - P_ONE;
      end else begin
        w_cyc_nxt  = r_period;
        w_tick_nxt = 1'b1;
        if (w_term) begin
          w_wrap_nxt = 1'b1;
          // A finished one-shot parks on the terminal value it already holds.
          if (w_oneshot) begin
            w_done_nxt = 1'b1;
          end else begin
            w_out_nxt = up ? '0 : r_limit;
          end
        end else begin
          w_out_nxt = up ? (r_out + P_CNT_ONE) : (r_out - P_CNT_ONE);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= P_DEF_PERIOD;
      r_limit  <= P_DEF_LIMIT;
      r_cyc    <= P_DEF_PERIOD;
      r_out    <= '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_period <= w_period_nxt;
      r_limit  <= w_limit_nxt;
      r_cyc    <= w_cyc_nxt;
      r_out    <= w_out_nxt;
      r_tick   <= w_tick_nxt;
      r_wrap   <= w_wrap_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign out  = r_out;
  assign tick = r_tick;
  assign wrap = r_wrap;
  assign done = r_done;

endmodule

// File: tb/tb_cyc_counter_prog.sv
// Directed bench for cyc_counter_prog: default-period counting, period-1 down count, load clamp,
// enable freeze, direction change, zero limit, async reset and one-shot behaviour.
module tb_cyc_counter_prog;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        cfg_wr;
  logic [29:0] period_in;
  logic [2:0]  limit_in;
  logic        load;
  logic [2:0]  load_val;
  logic        oneshot;
  logic [2:0]  out;
  logic        tick;
  logic        wrap;
  logic        done;

  int n_checks;
  int n_fail;

  cyc_counter_prog dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .cfg_wr    (cfg_wr),
    .period_in (period_in),
    .limit_in  (limit_in),
    .load      (load),
    .load_val  (load_val),
    .oneshot   (oneshot),
    .out       (out),
    .tick      (tick),
    .wrap      (wrap),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_cfg(input logic [29:0] p, input logic [2:0] l);
    period_in = p;
    limit_in  = l;
    cfg_wr    = 1'b1;
    step(1);
    cfg_wr    = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (out !== 3'd0) begin n_fail++; $display("FAIL reset_out got=%0d exp=0", out); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    en = 1'b1;
    step(3);
    n_checks++; if (out !== 3'd0) begin n_fail++; $display("FAIL reset_hold_out got=%0d exp=0", out); end
  endtask

  task automatic test_count_up;
    logic [2:0] e_out;
    logic       e_tick;
    logic       e_wrap;
    en  = 1'b1;
    up  = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      step(1);
      e_out  = 3'((i / 10) % 5);
      e_tick = (i % 10 == 0);
      e_wrap = (i % 50 == 0);
      n_checks++; if (out !== e_out) begin n_fail++; $display("FAIL up_out edge=%0d got=%0d exp=%0d", i, out, e_out); end
      n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL up_tick edge=%0d got=%b exp=%b", i, tick, e_tick); end
      n_checks++; if (wrap !== e_wrap) begin n_fail++; $display("FAIL up_wrap edge=%0d got=%b exp=%b", i, wrap, e_wrap); end
    end
  endtask

  task automatic test_cfg_down;
    logic [2:0] e_out;
    up = 1'b0;
    do_cfg(30'd0, 3'd6);
    n_checks++; if (out !== 3'd6) begin n_fail++; $display("FAIL cfg_start_out got=%0d exp=6", out); end
    n_checks++; if (tick !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL cfg_no_strobe got=%b%b exp=00", tick, wrap); end
    for (int i = 1; i <= 14; i++) begin
      step(1);
      e_out = 3'((13 - (i % 7)) % 7);
      n_checks++; if (out !== e_out) begin n_fail++; $display("FAIL down_out edge=%0d got=%0d exp=%0d", i, out, e_out); end
      n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL down_tick edge=%0d got=%b exp=1", i, tick); end
      n_checks++; if (wrap !== (e_out == 3'd6)) begin n_fail++; $display("FAIL down_wrap edge=%0d got=%b exp=%b", i, wrap, e_out == 3'd6); end
    end
  endtask

  task automatic test_load;
    up = 1'b1;
    do_cfg(30'd3, 3'd4);
    n_checks++; if (out !== 3'd0) begin n_fail++; $display("FAIL load_cfg_out got=%0d exp=0", out); end
    load = 1'b1; load_val = 3'd7;
    step(1);
    load = 1'b0;
    n_checks++; if (out !== 3'd4) begin n_fail++; $display("FAIL load_clamp_out got=%0d exp=4", out); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL load_tick got=%b exp=0", tick); end
    step(2);
    n_checks++; if (out !== 3'd4 || tick !== 1'b0) begin n_fail++; $display("FAIL load_wait got=%0d/%b exp=4/0", out, tick); end
    step(1);
    n_checks++; if (out !== 3'd0) begin n_fail++; $display("FAIL load_step_out got=%0d exp=0", out); end
    n_checks++; if (wrap !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL load_step_strobes got=%b%b exp=11", tick, wrap); end
    load = 1'b1; load_val = 3'd2;
    step(1);
    load = 1'b0;
    n_checks++; if (out !== 3'd2) begin n_fail++; $display("FAIL load_inrange got=%0d exp=2", out); end
    load = 1'b1; load_val = 3'd3; cfg_wr = 1'b1; period_in = 30'd1; limit_in = 3'd5;
    step(1);
    load = 1'b0; cfg_wr = 1'b0;
    n_checks++; if (out !== 3'd0) begin n_fail++; $display("FAIL cfg_over_load got=%0d exp=0", out); end
    step(1);
    n_checks++; if (out !== 3'd1) begin n_fail++; $display("FAIL cfg_over_load_step got=%0d exp=1", out); end
  endtask

  task automatic test_en_freeze;
    up = 1'b1;
    do_cfg(30'd5, 3'd4);
    step(2);
    en = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      n_checks++; if (out !== 3'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL freeze edge=%0d got=%0d/%b exp=0/0", i, out, tick); end
    end
    en = 1'b1;
    step(2);
    n_checks++; if (out !== 3'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL freeze_resume_wait got=%0d/%b exp=0/0", out, tick); end
    step(1);
    n_checks++; if (out !== 3'd1 || tick !== 1'b1) begin n_fail++; $display("FAIL freeze_resume_step got=%0d/%b exp=1/1", out, tick); end
  endtask

  task automatic test_dir_change;
    logic [2:0] seq [5];
    logic       dir [5];
    seq = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd4};
    dir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    up = 1'b1;
    do_cfg(30'd1, 3'd4);
    for (int i = 0; i < 5; i++) begin
      up = dir[i];
      step(1);
      n_checks++; if (out !== seq[i]) begin n_fail++; $display("FAIL dir_out idx=%0d got=%0d exp=%0d", i, out, seq[i]); end
    end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL dir_wrap got=%b exp=1", wrap); end
  endtask

  task automatic test_limit0;
    up = 1'b1;
    do_cfg(30'd1, 3'd0);
    n_checks++; if (out !== 3'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL lim0_cfg got=%0d/%b exp=0/0", out, tick); end
    for (int i = 1; i <= 4; i++) begin
      up = (i != 4);
      step(1);
      n_checks++; if (out !== 3'd0 || tick !== 1'b1 || wrap !== 1'b1) begin
        n_fail++; $display("FAIL lim0_step edge=%0d got=%0d/%b/%b exp=0/1/1", i, out, tick, wrap);
      end
    end
  endtask

  task automatic test_async_rst;
    up  = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    step(30);
    n_checks++; if (out !== 3'd3 || tick !== 1'b1) begin n_fail++; $display("FAIL arst_pre got=%0d/%b exp=3/1", out, tick); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out !== 3'd0) begin n_fail++; $display("FAIL arst_out got=%0d exp=0", out); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL arst_tick got=%b exp=0", tick); end
    rst = 1'b0;
    step(9);
    n_checks++; if (out !== 3'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL arst_wait got=%0d/%b exp=0/0", out, tick); end
    step(1);
    n_checks++; if (out !== 3'd1 || tick !== 1'b1) begin n_fail++; $display("FAIL arst_first_step got=%0d/%b exp=1/1", out, tick); end
  endtask

`ifdef CYC_COUNTER_ONESHOT_EN
  task automatic test_oneshot;
    logic [2:0] e_out;
    up = 1'b1;
    oneshot = 1'b1;
    do_cfg(30'd2, 3'd3);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      e_out = (i < 8) ? 3'(i / 2) : 3'd3;
      n_checks++; if (out !== e_out) begin n_fail++; $display("FAIL os_out edge=%0d got=%0d exp=%0d", i, out, e_out); end
      n_checks++; if (tick !== (i % 2 == 0 && i <= 8)) begin n_fail++; $display("FAIL os_tick edge=%0d got=%b", i, tick); end
      n_checks++; if (wrap !== (i == 8)) begin n_fail++; $display("FAIL os_wrap edge=%0d got=%b exp=%b", i, wrap, i == 8); end
      n_checks++; if (done !== (i >= 8)) begin n_fail++; $display("FAIL os_done edge=%0d got=%b exp=%b", i, done, i >= 8); end
    end
    load = 1'b1; load_val = 3'd0;
    step(1);
    load = 1'b0;
    n_checks++; if (out !== 3'd0 || done !== 1'b0) begin n_fail++; $display("FAIL os_load got=%0d/%b exp=0/0", out, done); end
    step(2);
    n_checks++; if (out !== 3'd1 || tick !== 1'b1) begin n_fail++; $display("FAIL os_resume got=%0d/%b exp=1/1", out, tick); end
    oneshot = 1'b0;
  endtask
`else
  task automatic test_oneshot;
    up = 1'b1;
    oneshot = 1'b1;
    do_cfg(30'd1, 3'd1);
    step(1);
    n_checks++; if (out !== 3'd1) begin n_fail++; $display("FAIL os_off_step got=%0d exp=1", out); end
    step(1);
    n_checks++; if (out !== 3'd0 || wrap !== 1'b1) begin n_fail++; $display("FAIL os_off_wrap got=%0d/%b exp=0/1", out, wrap); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL os_off_done got=%b exp=0", done); end
    oneshot = 1'b0;
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    en        = 1'b0;
    up        = 1'b1;
    cfg_wr    = 1'b0;
    period_in = '0;
    limit_in  = '0;
    load      = 1'b0;
    load_val  = '0;
    oneshot   = 1'b0;
    test_reset();
    test_count_up();
    test_cfg_down();
    test_load();
    test_en_freeze();
    test_dir_change();
    test_limit0();
    test_async_rst();
    test_oneshot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
